// File: rtl/core_fan_tach_pkg.sv
// +----------------------------------------------------------------------------+
// | core_fan_tach_pkg                                                          |
// | Register map, status bit positions and helpers shared by the tach core.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package core_fan_tach_pkg;

  localparam logic [1:0] ADDR_COUNT  = 2'd0;
  localparam logic [1:0] ADDR_WINDOW = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_STALL = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_VALID = 2;
  localparam int STAT_W     = 3;

  localparam int RD_VALID_BIT = 31;
  localparam int RD_OVF_BIT   = 30;

  localparam int SYNC_STAGES = 2;

  // A zero-length window would never tick, so it is promoted to one cycle.
  function automatic logic [31:0] window_sanitize(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fan_tach_sync.sv
// +----------------------------------------------------------------------------+
// | core_fan_tach_sync                                                         |
// | Two-flop synchronizer plus delay flop; flags rising edges of the input.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_fan_tach_sync
  import core_fan_tach_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

`default_nettype wire

// File: rtl/core_fan_tach.sv
// +----------------------------------------------------------------------------+
// | core_fan_tach                                                              |
// | Fan tachometer: counts pulses per window, Avalon-MM registers, stall irq.  |
// | Optional macro CORE_FAN_TACH_IRQ_EN enables the mask register and irq.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_fan_tach
  import core_fan_tach_pkg::*;
#(
  parameter int unsigned WINDOW_DEFAULT = 50000000,
  parameter int          CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        tach_in,
  output logic        irq
);

  localparam logic [31:0]      WIN_RST = window_sanitize(32'(WINDOW_DEFAULT));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]       window_q,  window_d;
  logic [31:0]       win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  pulse_q,   pulse_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [STAT_W-1:0] status_q,  status_d;

  logic              w_tach_edge;
  logic              w_tick;
  logic              w_wr;
  logic              w_wr_window;
  logic              w_wr_status;
  logic [CNT_W-1:0]  w_latched;
  logic [STAT_W-1:0] w_status_set;
  logic [STAT_W-1:0] w_status_clr;
  logic              w_mask_rd;

  core_fan_tach_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (tach_in),
    .edge_o  (w_tach_edge)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_window = w_wr && (address == ADDR_WINDOW);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_tick      = (win_cnt_q == 32'd0);

  // Pulse count including an edge landing this cycle, held at all-ones.
  assign w_latched = (w_tach_edge && (pulse_q != CNT_MAX)) ? pulse_q + 1'b1 : pulse_q;

  always_comb begin
    window_d  = window_q;
    win_cnt_d = win_cnt_q - 32'd1;
    pulse_d   = w_latched;
    count_d   = count_q;
    if (w_tick) begin
      win_cnt_d = window_q - 32'd1;
      pulse_d   = CNT_W'(w_tach_edge);
      count_d   = w_latched;
    end
    // A window write restarts measurement from a clean count.
    if (w_wr_window) begin
      window_d  = window_sanitize(writedata);
      win_cnt_d = window_sanitize(writedata) - 32'd1;
      pulse_d   = '0;
    end
  end

  always_comb begin
    w_status_set             = '0;
    w_status_set[STAT_STALL] = w_tick && (w_latched == '0);
    w_status_set[STAT_OVF]   = w_tick && (w_latched == CNT_MAX);
    w_status_set[STAT_VALID] = w_tick;
    w_status_clr             = w_wr_status ? writedata[STAT_W-1:0] : '0;
    status_d                 = w_status_set | (status_q & ~w_status_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q  <= WIN_RST;
      win_cnt_q <= WIN_RST - 32'd1;
      pulse_q   <= '0;
      count_q   <= '0;
      status_q  <= '0;
    end else begin
      window_q  <= window_d;
      win_cnt_q <= win_cnt_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
      status_q  <= status_d;
    end
  end

`ifdef CORE_FAN_TACH_IRQ_EN
  logic w_wr_mask;
  logic mask_q, mask_d;

  assign w_wr_mask = w_wr && (address == ADDR_MASK);

  always_comb begin
    mask_d = mask_q;
    if (w_wr_mask) mask_d = writedata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) mask_q <= 1'b0;
    else       mask_q <= mask_d;
  end

  assign w_mask_rd = mask_q;
`else
  assign w_mask_rd = 1'b0;
`endif

  assign irq = status_q[STAT_STALL] & w_mask_rd;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_COUNT: begin
        readdata               = 32'(count_q);
        readdata[RD_VALID_BIT] = status_q[STAT_VALID];
        readdata[RD_OVF_BIT]   = status_q[STAT_OVF];
      end
      ADDR_WINDOW: readdata = window_q;
      ADDR_MASK:   readdata = {31'd0, w_mask_rd};
      ADDR_STATUS: readdata = {{(32-STAT_W){1'b0}}, status_q};
      default:     readdata = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_core_fan_tach.sv
// +----------------------------------------------------------------------------+
// | tb_core_fan_tach                                                           |
// | Self-checking bench for core_fan_tach with a window/edge reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_core_fan_tach;

  localparam int WDEF = 64;
  localparam int CW   = 8;
`ifdef CORE_FAN_TACH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic        tach_in    = 1'b0;
  logic [31:0] readdata;
  logic        irq;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int last_wr = 0;
  bit hist [0:16383];

  core_fan_tach #(.WINDOW_DEFAULT(WDEF), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .tach_in    (tach_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // hist[p] is tach_in as seen by posedge p (forced low while in reset).
  always @(posedge clk) begin
    if (cyc < 16384) hist[cyc] <= reset ? 1'b0 : tach_in;
    cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // A tach rise first sampled at posedge p is counted at posedge p+2.
  function automatic bit edge_at(input int c);
    if (c < 3 || c > 16383) return 1'b0;
    return hist[c-2] && !hist[c-3];
  endfunction

  function automatic int model_count(input int lo, input bit incl, input int hi);
    int n = 0;
    for (int c = (incl ? lo : lo + 1); c <= hi; c++) n += int'(edge_at(c));
    return (n > 255) ? 255 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    last_wr = cyc - 1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_past(input int t);
    int guard = 0;
    while (cyc <= t && guard < 5000) begin step(); guard++; end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_count: got %h expected %h", rd, 32'd0); end
    bus_read(2'd1, rd); tests++;
    if (rd !== 32'(WDEF)) begin fails++; $display("FAIL reset_window: got %h expected %h", rd, 32'(WDEF)); end
    bus_read(2'd2, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_mask: got %h expected %h", rd, 32'd0); end
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_status: got %h expected %h", rd, 32'd0); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_count_window();
    logic [31:0] rd;
    int w, k;
    bus_write(2'd1, 32'd100); w = last_wr;
    bus_write(2'd3, 32'd7);
    while (cyc <= w + 100) begin
      k = cyc - (w + 4);
      tach_in = (k >= 0 && k < 80 && (k % 8) < 4);
      step();
    end
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'h8000000A) begin fails++; $display("FAIL count_10: got %h expected %h", rd, 32'h8000000A); end
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd4) begin fails++; $display("FAIL count_status: got %h expected %h", rd, 32'd4); end
  endtask

  task automatic test_stall_irq();
    logic [31:0] rd;
    int w;
    tach_in = 1'b0;
    bus_write(2'd1, 32'd100); w = last_wr;
    bus_write(2'd3, 32'd7);
    bus_write(2'd2, 32'd1);
    wait_past(w + 100);
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd5) begin fails++; $display("FAIL stall_status: got %h expected %h", rd, 32'd5); end
    bus_read(2'd2, rd); tests++;
    if (rd !== 32'(IRQ_EN)) begin fails++; $display("FAIL stall_mask_rd: got %h expected %h", rd, 32'(IRQ_EN)); end
    tests++;
    if (irq !== IRQ_EN) begin fails++; $display("FAIL stall_irq: got %b expected %b", irq, IRQ_EN); end
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'h80000000) begin fails++; $display("FAIL stall_count: got %h expected %h", rd, 32'h80000000); end
    bus_write(2'd3, 32'd1);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL stall_irq_clear: got %b expected 0", irq); end
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd4) begin fails++; $display("FAIL stall_w1c: got %h expected %h", rd, 32'd4); end
    bus_write(2'd2, 32'd0);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int w, k;
    bus_write(2'd1, 32'd2000); w = last_wr;
    bus_write(2'd3, 32'd7);
    while (cyc <= w + 2000) begin
      k = cyc - (w + 4);
      tach_in = (k >= 0 && k < 1200 && (k % 4) < 2);
      step();
    end
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'hC00000FF) begin fails++; $display("FAIL ovf_count: got %h expected %h", rd, 32'hC00000FF); end
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd6) begin fails++; $display("FAIL ovf_status: got %h expected %h", rd, 32'd6); end
  endtask

  task automatic test_coincide();
    logic [31:0] rd;
    int w, t, p;
    bus_write(2'd1, 32'd20); w = last_wr; t = w + 20;
    bus_write(2'd3, 32'd7);
    while (cyc <= t + 20) begin
      p = cyc;
      tach_in = (p >= w + 5 && p < w + 7) || (p >= t - 2 && p <= t);
      step();
      if (cyc - 1 == t) begin
        bus_read(2'd0, rd); tests++;
        if (rd !== 32'h80000002) begin fails++; $display("FAIL coincide_latched: got %h expected %h", rd, 32'h80000002); end
        bus_read(2'd3, rd); tests++;
        if (rd !== 32'd4) begin fails++; $display("FAIL coincide_status: got %h expected %h", rd, 32'd4); end
      end
    end
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'h80000001) begin fails++; $display("FAIL coincide_next: got %h expected %h", rd, 32'h80000001); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp;
    int w, wl, dens, m;
    bit s_stall, s_ovf;
    for (int it = 0; it < 6; it++) begin
      wl = $urandom_range(16, 60);
      dens = $urandom_range(0, 3);
      bus_write(2'd1, 32'(wl)); w = last_wr;
      bus_write(2'd3, 32'd7);
      s_stall = 1'b0; s_ovf = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        while (cyc <= w + k * wl) begin
          tach_in = ($urandom_range(0, 3) < dens);
          step();
        end
        m = model_count(w + (k - 1) * wl, k != 1, w + k * wl);
        if (m == 0) s_stall = 1'b1;
        if (m == 255) s_ovf = 1'b1;
        exp = {1'b1, s_ovf, 22'd0, 8'(m)};
        bus_read(2'd0, rd); tests++;
        if (rd !== exp) begin fails++; $display("FAIL random_count it%0d win%0d: got %h expected %h", it, k, rd, exp); end
      end
      exp = {29'd0, 1'b1, s_ovf, s_stall};
      bus_read(2'd3, rd); tests++;
      if (rd !== exp) begin fails++; $display("FAIL random_status it%0d: got %h expected %h", it, rd, exp); end
    end
    tach_in = 1'b0;
  endtask

  task automatic test_window_zero();
    logic [31:0] rd, exp;
    int w, p, m;
    tach_in = 1'b0;
    bus_write(2'd1, 32'd0); w = last_wr;
    bus_write(2'd3, 32'd7);
    bus_read(2'd1, rd); tests++;
    if (rd !== 32'd1) begin fails++; $display("FAIL win0_readback: got %h expected %h", rd, 32'd1); end
    for (int i = 0; i < 10; i++) begin
      p = cyc;
      tach_in = (p == w + 4 || p == w + 5);
      step();
      m = model_count(p - 1, 1'b1, p);
      exp = {2'b10, 22'd0, 8'(m)};
      bus_read(2'd0, rd); tests++;
      if (rd !== exp) begin fails++; $display("FAIL win0_tick cyc%0d: got %h expected %h", p, rd, exp); end
    end
    tach_in = 1'b0;
    step(); step(); step();
    bus_write(2'd3, 32'd7);
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd5) begin fails++; $display("FAIL win0_set_wins: got %h expected %h", rd, 32'd5); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int r;
    bus_write(2'd1, 32'd100);
    for (int i = 0; i < 20; i++) begin tach_in = ((i % 4) < 2); step(); end
    tach_in = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    r = cyc - 1;
    bus_read(2'd0, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_count: got %h expected %h", rd, 32'd0); end
    bus_read(2'd1, rd); tests++;
    if (rd !== 32'(WDEF)) begin fails++; $display("FAIL mid_window: got %h expected %h", rd, 32'(WDEF)); end
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_status: got %h expected %h", rd, 32'd0); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq: got %b expected 0", irq); end
    wait_past(r + WDEF - 1);
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_pre_tick: got %h expected %h", rd, 32'd0); end
    wait_past(r + WDEF);
    bus_read(2'd3, rd); tests++;
    if (rd !== 32'd5) begin fails++; $display("FAIL mid_default_tick: got %h expected %h", rd, 32'd5); end
  endtask

  task automatic test_mask_cfg();
    logic [31:0] rd;
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2, rd); tests++;
    if (rd !== 32'(IRQ_EN)) begin fails++; $display("FAIL mask_cfg_rd: got %h expected %h", rd, 32'(IRQ_EN)); end
    tests++;
    if (irq !== IRQ_EN) begin fails++; $display("FAIL mask_cfg_irq: got %b expected %b", irq, IRQ_EN); end
  endtask

  initial begin
    test_reset();
    test_count_window();
    test_stall_irq();
    test_overflow();
    test_coincide();
    test_random();
    test_window_zero();
    test_reset_mid();
    test_mask_cfg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
